// File: rtl/btn_cond_pkg.sv
// Shared definitions for the two-channel push-button conditioner.
// Holds the per-channel debounce FSM state encoding.
package btn_cond_pkg;

    typedef enum logic [1:0] {
        StZero  = 2'b00,
        StWait1 = 2'b01,
        StOne   = 2'b10,
        StWait0 = 2'b11
    } db_state_e;

    localparam int unsigned DefaultDbCycles = 2000000;
    localparam int unsigned DefaultCntW     = 24;

endpackage

// File: rtl/debounce_ch.sv
// Single push-button channel: 2-flop synchronizer, stability counter and debounce FSM
// with a registered level and a one-cycle rising-edge tick.
module debounce_ch
    import btn_cond_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DefaultDbCycles,
    parameter int unsigned CNT_W     = DefaultCntW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic tick
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

    logic             sync_q;
    logic             s_q;
    db_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             tick_q;

    // Level and tick are updated together with the state, so they rise in the
    // same cycle the FSM enters StOne.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 1'b0;
            s_q     <= 1'b0;
            state_q <= StZero;
            cnt_q   <= '0;
            level_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync_q <= raw;
            s_q    <= sync_q;
            tick_q <= 1'b0;
            case (state_q)
                StZero: begin
                    if (s_q) begin
                        state_q <= StWait1;
                        cnt_q   <= '0;
                    end
                end
                StWait1: begin
                    if (!s_q) begin
                        state_q <= StZero;
                    end else if (cnt_q == CntMax) begin
                        state_q <= StOne;
                        level_q <= 1'b1;
                        tick_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StOne: begin
                    if (!s_q) begin
                        state_q <= StWait0;
                        cnt_q   <= '0;
                    end
                end
                StWait0: begin
                    if (s_q) begin
                        state_q <= StOne;
                    end else if (cnt_q == CntMax) begin
                        state_q <= StZero;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StZero;
            endcase
        end
    end

    assign level = level_q;
    assign tick  = tick_q;

endmodule

// File: rtl/btn_cond_2ch.sv
// Two independent debounced push-button channels feeding the downstream FSM inputs a and b,
// each with a one-cycle press tick.
module btn_cond_2ch
    import btn_cond_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DefaultDbCycles,
    parameter int unsigned CNT_W     = DefaultCntW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_a_raw,
    input  logic btn_b_raw,
    output logic a,
    output logic b,
    output logic a_tick,
    output logic b_tick
);

    debounce_ch #(
        .DB_CYCLES(DB_CYCLES),
        .CNT_W    (CNT_W)
    ) u_ch_a (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (btn_a_raw),
        .level(a),
        .tick (a_tick)
    );

    debounce_ch #(
        .DB_CYCLES(DB_CYCLES),
        .CNT_W    (CNT_W)
    ) u_ch_b (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (btn_b_raw),
        .level(b),
        .tick (b_tick)
    );

endmodule

// File: tb/tb_btn_cond_2ch.sv
// Directed self-checking bench for btn_cond_2ch with DB_CYCLES=4; outputs are sampled
// 1 time unit after each rising edge as the vector {a, b, a_tick, b_tick}.
module tb_btn_cond_2ch;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_a_raw;
    logic btn_b_raw;
    logic a, b, a_tick, b_tick;
    logic [3:0] outs;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    btn_cond_2ch #(
        .DB_CYCLES(4),
        .CNT_W    (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_a_raw(btn_a_raw),
        .btn_b_raw(btn_b_raw),
        .a        (a),
        .b        (b),
        .a_tick   (a_tick),
        .b_tick   (b_tick)
    );

    assign outs = {a, b, a_tick, b_tick};

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got {a,b,at,bt}=%b expected %b at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Eight edges r0..r0+7 after an input change; levels switch and ticks fire after r0+6.
    task automatic window(input string tag, input logic [1:0] lvl_before,
                          input logic [1:0] lvl_after, input logic [1:0] tick_mask);
        logic [1:0] lvl;
        logic [1:0] tk;
        for (int k = 0; k < 8; k++) begin
            step();
            lvl = (k >= 6) ? lvl_after : lvl_before;
            tk  = (k == 6) ? tick_mask : 2'b00;
            check_eq($sformatf("%s_r%0d", tag, k), outs, {lvl, tk});
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        btn_a_raw = 1'b0;
        btn_b_raw = 1'b0;
        repeat (3) step();
        check_eq("reset_state", outs, 4'b0000);
        rst_n = 1'b1;
        repeat (2) step();
        check_eq("idle", outs, 4'b0000);

        // Clean press on A; B must stay quiet.
        btn_a_raw = 1'b1;
        window("press_a", 2'b00, 2'b10, 2'b10);
        repeat (3) step();
        check_eq("press_a_hold", outs, 4'b1000);

        // Release A: no tick on the falling side.
        btn_a_raw = 1'b0;
        window("release_a", 2'b10, 2'b00, 2'b00);
        step();
        check_eq("release_a_hold", outs, 4'b0000);

        // Bounce: 2-cycle toggles never survive DB_CYCLES stable samples.
        for (int i = 0; i < 40; i++) begin
            btn_a_raw = ((i >> 1) % 2 == 0);
            step();
            check_eq($sformatf("bounce_%0d", i), outs, 4'b0000);
        end
        btn_a_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq($sformatf("bounce_tail_%0d", i), outs, 4'b0000);
        end

        // Glitch of 3 samples on A while high must not release it.
        btn_a_raw = 1'b1;
        window("press_a2", 2'b00, 2'b10, 2'b10);
        btn_a_raw = 1'b0;
        repeat (3) step();
        btn_a_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq($sformatf("glitch_low_%0d", i), outs, 4'b1000);
        end
        btn_a_raw = 1'b0;
        window("release_a2", 2'b10, 2'b00, 2'b00);

        // Press B alone.
        btn_b_raw = 1'b1;
        window("press_b", 2'b00, 2'b01, 2'b01);
        btn_b_raw = 1'b0;
        window("release_b", 2'b01, 2'b00, 2'b00);

        // Simultaneous press and release on both channels.
        btn_a_raw = 1'b1;
        btn_b_raw = 1'b1;
        window("press_ab", 2'b00, 2'b11, 2'b11);
        btn_a_raw = 1'b0;
        btn_b_raw = 1'b0;
        window("release_ab", 2'b11, 2'b00, 2'b00);

        // Reset asserted at edge r0+4 mid-qualification; requalify from scratch at r0+5.
        btn_a_raw = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq($sformatf("midq_r%0d", k), outs, 4'b0000);
        end
        rst_n = 1'b0;
        step();
        check_eq("midq_reset", outs, 4'b0000);
        rst_n = 1'b1;
        window("midq_requal", 2'b00, 2'b10, 2'b10);

        // Reset with A high and still held: outputs clear, then full requalification.
        rst_n = 1'b0;
        step();
        check_eq("held_reset", outs, 4'b0000);
        rst_n = 1'b1;
        window("held_requal", 2'b00, 2'b10, 2'b10);
        repeat (4) step();
        check_eq("held_final", outs, 4'b1000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
